// File: rtl/ro_puf_ctrl.sv
// Ring-oscillator PUF challenge controller.
// Races two RO counters per bit and packs the winners into a response word.
module ro_puf_ctrl #(
    parameter int NBITS   = 8,
    parameter int PAIR_W  = 4,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PAIR_W-1:0] challenge,
    input  logic [3:0]        count1,
    input  logic [3:0]        count2,
    output logic [PAIR_W-1:0] pair_sel,
    output logic              ro_en,
    output logic              cnt_clr,
    output logic              busy,
    output logic              done,
    output logic [NBITS-1:0]  response,
    output logic              timeout_err,
    output logic              tie_err
);

    localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int SW = $clog2(SETTLE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_NEXT    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [PAIR_W-1:0] base_q, base_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [SW-1:0]     settle_q, settle_d;
    logic [NBITS-1:0]  resp_q, resp_d;
    logic              tout_q, tout_d;
    logic              tie_q, tie_d;

    logic [3:0] c1_meta_q, s1_q;
    logic [3:0] c2_meta_q, s2_q;
    logic       f1, f2;

    // Two-flop synchronizers for the free-running RO counter values
    always_ff @(posedge clk) begin
        if (rst) begin
            c1_meta_q <= '0;
            s1_q      <= '0;
            c2_meta_q <= '0;
            s2_q      <= '0;
        end else begin
            c1_meta_q <= count1;
            s1_q      <= c1_meta_q;
            c2_meta_q <= count2;
            s2_q      <= c2_meta_q;
        end
    end

    assign f1 = (s1_q == 4'hF);
    assign f2 = (s2_q == 4'hF);

    // Next-state and datapath update for the challenge sequencer
    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        settle_d = settle_q;
        resp_d   = resp_q;
        tout_d   = tout_q;
        tie_d    = tie_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d   = challenge;
                    idx_d    = '0;
                    resp_d   = '0;
                    tout_d   = 1'b0;
                    tie_d    = 1'b0;
                    settle_d = '0;
                    state_d  = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (settle_q == SW'(SETTLE - 1)) begin
                    timer_d = '0;
                    state_d = S_RUN;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            S_RUN: begin
                if (f1 || f2 || (timer_q == TW'(TIMEOUT))) begin
                    state_d = S_CAPTURE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_CAPTURE: begin
                if (f1 && !f2) begin
                    resp_d[idx_q] = 1'b1;
                end else if (f2 && !f1) begin
                    resp_d[idx_q] = 1'b0;
                end else if (f1 && f2) begin
                    resp_d[idx_q] = 1'b0;
                    tie_d         = 1'b1;
                end else begin
                    resp_d[idx_q] = 1'b0;
                    tout_d        = 1'b1;
                end
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (idx_q == IW'(NBITS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    idx_d    = idx_q + 1'b1;
                    settle_d = '0;
                    state_d  = S_CLEAR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any run in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            idx_q    <= '0;
            timer_q  <= '0;
            settle_q <= '0;
            resp_q   <= '0;
            tout_q   <= 1'b0;
            tie_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            idx_q    <= idx_d;
            timer_q  <= timer_d;
            settle_q <= settle_d;
            resp_q   <= resp_d;
            tout_q   <= tout_d;
            tie_q    <= tie_d;
        end
    end

    // Counters are held cleared while in reset as well as during CLEAR
    assign cnt_clr     = rst | (state_q == S_CLEAR);
    assign ro_en       = (state_q == S_RUN);
    assign busy        = (state_q == S_CLEAR) | (state_q == S_RUN) |
                         (state_q == S_CAPTURE) | (state_q == S_NEXT);
    assign done        = (state_q == S_DONE);
    assign pair_sel    = base_q + PAIR_W'(idx_q);
    assign response    = resp_q;
    assign timeout_err = tout_q;
    assign tie_err     = tie_q;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Self-checking bench for ro_puf_ctrl.
// Counter stimulus is modelled as ROs counting at per-bit periods.
module tb_ro_puf_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       start2;
    logic [3:0] challenge;
    logic [3:0] count1, count2;
    logic [3:0] frz = 4'h7;

    logic [3:0] pair_sel;
    logic       ro_en, cnt_clr, busy, done;
    logic [7:0] response;
    logic       timeout_err, tie_err;

    logic [3:0] pair_sel_b;
    logic       ro_en_b, cnt_clr_b, busy_b, done_b;
    logic [7:0] response_b;
    logic       timeout_err_b, tie_err_b;

    always #5 clk = ~clk;

    ro_puf_ctrl #(.NBITS(8), .PAIR_W(4), .SETTLE(3), .TIMEOUT(1023)) u_dut (
        .clk(clk), .rst(rst), .start(start), .challenge(challenge),
        .count1(count1), .count2(count2), .pair_sel(pair_sel),
        .ro_en(ro_en), .cnt_clr(cnt_clr), .busy(busy), .done(done),
        .response(response), .timeout_err(timeout_err), .tie_err(tie_err)
    );

    ro_puf_ctrl #(.NBITS(8), .PAIR_W(4), .SETTLE(3), .TIMEOUT(15)) u_dut_to (
        .clk(clk), .rst(rst), .start(start2), .challenge(challenge),
        .count1(frz), .count2(frz), .pair_sel(pair_sel_b),
        .ro_en(ro_en_b), .cnt_clr(cnt_clr_b), .busy(busy_b), .done(done_b),
        .response(response_b), .timeout_err(timeout_err_b), .tie_err(tie_err_b)
    );

    int errors = 0;
    int checks = 0;

    // RO model: each counter advances once every p cycles while enabled
    int         p1[8];
    int         p2[8];
    int         bitn = -1;
    int         jcnt = 0;
    logic [3:0] c1 = 4'h0, c2 = 4'h0;
    logic       clr_prev = 1'b0;

    always @(negedge clk) begin
        if (cnt_clr && !clr_prev) bitn = bitn + 1;
        clr_prev = cnt_clr;
        if (cnt_clr) begin
            c1 = 4'h0; c2 = 4'h0; jcnt = 0;
        end else if (ro_en && bitn >= 0 && bitn < 8) begin
            jcnt = jcnt + 1;
            if (jcnt % p1[bitn] == 0 && c1 != 4'hF) c1 = c1 + 4'h1;
            if (jcnt % p2[bitn] == 0 && c2 != 4'hF) c2 = c2 + 4'h1;
        end
        count1 = c1;
        count2 = c2;
    end

    // Reference model results
    logic [7:0] exp_resp;
    logic       exp_tie, exp_tout;
    int         exp_lat;
    logic [3:0] exp_ps[8];

    task automatic model(input logic [3:0] ch, input int to);
        int pm, run;
        exp_resp = 8'h00; exp_tie = 1'b0; exp_tout = 1'b0;
        exp_lat  = 8 * (3 + 2) + 1;
        for (int b = 0; b < 8; b++) begin
            pm  = (p1[b] < p2[b]) ? p1[b] : p2[b];
            run = 15 * pm + 2;
            if (run > to + 1) begin
                run = to + 1; exp_tout = 1'b1;
            end else if (p1[b] == p2[b]) begin
                exp_tie = 1'b1;
            end else if (p1[b] < p2[b]) begin
                exp_resp[b] = 1'b1;
            end
            exp_lat += run;
            exp_ps[b] = 4'((int'(ch) + b) % 16);
        end
    endtask

    // Observations of one run on the main instance
    logic       obs_ok;
    int         obs_lat, obs_np, obs_dones, obs_busy_bad, obs_hold_bad;
    logic [7:0] obs_resp;
    logic       obs_tout, obs_tie;
    logic [3:0] obs_ps[8];

    task automatic run_challenge(input logic [3:0] ch, input int pulse_at,
                                 input logic [3:0] other);
        int   cyc;
        logic prev_ro;
        @(negedge clk);
        bitn = -1; challenge = ch; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1; prev_ro = 1'b0; obs_np = 0; obs_busy_bad = 0;
        obs_hold_bad = 0;
        while (!done && cyc < 3000) begin
            if (!busy) obs_busy_bad++;
            if (ro_en && !prev_ro && obs_np < 8) begin
                obs_ps[obs_np] = pair_sel; obs_np++;
            end
            prev_ro = ro_en;
            if (cyc == pulse_at) begin
                start = 1'b1; challenge = other;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        obs_ok = done; obs_lat = cyc;
        if (busy) obs_busy_bad++;
        obs_resp = response; obs_tout = timeout_err; obs_tie = tie_err;
        obs_dones = done ? 1 : 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (done) obs_dones++;
            if (busy) obs_busy_bad++;
            if (response !== obs_resp) obs_hold_bad++;
        end
    endtask

    task automatic check_run(input string nm, input int exp_dones);
        checks++;
        if (obs_ok !== 1'b1)
            $display("FAIL %s_done: got no done, expected done", nm);
        checks++;
        if (obs_resp !== exp_resp)
            $display("FAIL %s_resp: got %h expected %h", nm, obs_resp, exp_resp);
        checks++;
        if (obs_lat != exp_lat)
            $display("FAIL %s_lat: got %0d expected %0d", nm, obs_lat, exp_lat);
        checks++;
        if (obs_tie !== exp_tie || obs_tout !== exp_tout)
            $display("FAIL %s_err: got tie=%b tout=%b expected tie=%b tout=%b",
                     nm, obs_tie, obs_tout, exp_tie, exp_tout);
        checks++;
        if (obs_dones != exp_dones)
            $display("FAIL %s_dones: got %0d expected %0d", nm, obs_dones, exp_dones);
        checks++;
        if (obs_busy_bad != 0 || obs_hold_bad != 0)
            $display("FAIL %s_busy_hold: got busy_bad=%0d hold_bad=%0d expected 0",
                     nm, obs_busy_bad, obs_hold_bad);
        checks++;
        if (obs_np != 8)
            $display("FAIL %s_npairs: got %0d expected 8", nm, obs_np);
        for (int b = 0; b < 8 && b < obs_np; b++) begin
            checks++;
            if (obs_ps[b] !== exp_ps[b])
                $display("FAIL %s_pair%0d: got %h expected %h",
                         nm, b, obs_ps[b], exp_ps[b]);
        end
        errors += (obs_ok !== 1'b1) + (obs_resp !== exp_resp) +
                  (obs_lat != exp_lat) + (obs_dones != exp_dones) +
                  (obs_tie !== exp_tie || obs_tout !== exp_tout) +
                  (obs_busy_bad != 0 || obs_hold_bad != 0) + (obs_np != 8);
        for (int b = 0; b < 8 && b < obs_np; b++)
            if (obs_ps[b] !== exp_ps[b]) errors++;
    endtask

    task automatic rand_periods();
        for (int b = 0; b < 8; b++) begin
            p1[b] = $urandom_range(1, 3);
            do p2[b] = $urandom_range(1, 3); while (p2[b] == p1[b]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; challenge = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (cnt_clr !== 1'b1 || busy !== 1'b0 || ro_en !== 1'b0 ||
            done !== 1'b0 || response !== 8'h00 || pair_sel !== 4'h0 ||
            timeout_err !== 1'b0 || tie_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got clr=%b busy=%b ro=%b done=%b resp=%h ps=%h expected 1 0 0 0 00 0",
                     cnt_clr, busy, ro_en, done, response, pair_sel);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cnt_clr !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got clr=%b busy=%b expected 0 0", cnt_clr, busy);
        end
        @(negedge clk); rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || cnt_clr !== 1'b0) begin
            errors++;
            $display("FAIL reset_prio: got busy=%b clr=%b expected 0 0", busy, cnt_clr);
        end
    endtask

    task automatic test_nominal();
        for (int b = 0; b < 8; b++) begin
            p1[b] = (b % 2 == 0) ? 1 : 2;
            p2[b] = (b % 2 == 0) ? 2 : 1;
        end
        model(4'h3, 1023);
        run_challenge(4'h3, -1, 4'h0);
        check_run("nominal", 1);
        checks++;
        if (obs_resp !== 8'h55) begin
            errors++;
            $display("FAIL nominal_55: got %h expected 55", obs_resp);
        end
    endtask

    task automatic test_wrap();
        rand_periods();
        model(4'hE, 1023);
        run_challenge(4'hE, -1, 4'h0);
        check_run("wrap", 1);
    endtask

    task automatic test_tie();
        rand_periods();
        p1[1] = 2; p2[1] = 2;
        model(4'h6, 1023);
        run_challenge(4'h6, -1, 4'h0);
        check_run("tie", 1);
    endtask

    task automatic test_timeout();
        int cyc, runlen, nrun, badrun;
        for (int b = 0; b < 8; b++) begin
            p1[b] = 1000; p2[b] = 1000;
        end
        model(4'h2, 15);
        @(negedge clk);
        challenge = 4'h2; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        cyc = 1; runlen = 0; nrun = 0; badrun = 0;
        while (!done_b && cyc < 1000) begin
            if (ro_en_b) begin
                runlen++;
            end else if (runlen > 0) begin
                nrun++;
                if (runlen != 16) badrun++;
                runlen = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (done_b !== 1'b1 || cyc != exp_lat) begin
            errors++;
            $display("FAIL timeout_lat: got done=%b cyc=%0d expected 1 %0d",
                     done_b, cyc, exp_lat);
        end
        checks++;
        if (nrun != 8 || badrun != 0) begin
            errors++;
            $display("FAIL timeout_runlen: got runs=%0d bad=%0d expected 8 0", nrun, badrun);
        end
        checks++;
        if (response_b !== 8'h00 || timeout_err_b !== 1'b1 || tie_err_b !== 1'b0) begin
            errors++;
            $display("FAIL timeout_flags: got resp=%h tout=%b tie=%b expected 00 1 0",
                     response_b, timeout_err_b, tie_err_b);
        end
    endtask

    task automatic test_reset_midrun();
        int k, dn;
        for (int b = 0; b < 8; b++) begin
            p1[b] = 2; p2[b] = 3;
        end
        @(negedge clk);
        bitn = -1; challenge = 4'h5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 0;
        while (!(bitn == 3 && ro_en) && k < 1000) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (!(bitn == 3 && ro_en === 1'b1)) begin
            errors++;
            $display("FAIL midrun_reach: got bit=%0d ro_en=%b expected 3 1", bitn, ro_en);
        end
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || ro_en !== 1'b0 || response !== 8'h00 ||
            done !== 1'b0 || pair_sel !== 4'h0) begin
            errors++;
            $display("FAIL midrun_abort: got busy=%b ro=%b resp=%h done=%b ps=%h expected 0 0 00 0 0",
                     busy, ro_en, response, done, pair_sel);
        end
        dn = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done || busy) dn++;
        end
        checks++;
        if (dn != 0) begin
            errors++;
            $display("FAIL midrun_quiet: got %0d active cycles expected 0", dn);
        end
        rand_periods();
        model(4'h9, 1023);
        run_challenge(4'h9, -1, 4'h0);
        check_run("after_reset", 1);
    endtask

    task automatic test_start_ignored();
        rand_periods();
        model(4'h4, 1023);
        run_challenge(4'h4, 25, 4'hB);
        check_run("ignored", 1);
    endtask

    task automatic test_random();
        logic [3:0] ch;
        for (int r = 0; r < 3; r++) begin
            rand_periods();
            if (r == 1) p1[$urandom_range(0, 7)] = p2[0];
            ch = 4'($urandom_range(0, 15));
            for (int b = 0; b < 8; b++)
                if (p1[b] == p2[b]) p2[b] = p1[b];
            model(ch, 1023);
            run_challenge(ch, -1, 4'h0);
            check_run("random", 1);
        end
    endtask

    initial begin
        for (int b = 0; b < 8; b++) begin
            p1[b] = 1; p2[b] = 2;
        end
        test_reset();
        test_nominal();
        test_wrap();
        test_tie();
        test_timeout();
        test_reset_midrun();
        test_start_ignored();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
